reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter: DATA_W, 16, register data width in bits.
REQ-002 Fixed constants: NREGS = 8, ADDR_W = 3. Address widths match the 3-bit destination-select mux output that drives wb_addr/alloc_addr.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 alloc_en  in  1  issue-stage request to reserve a destination register.
REQ-007 alloc_addr  in  3  destination to reserve (from the rd/rt select mux).
REQ-008 alloc_ok  out  1  reservation accepted this cycle; 0 means issue shall stall.
REQ-009 wb_en  in  1  write-back strobe.
REQ-010 wb_addr  in  3  write-back destination.
REQ-011 wb_data  in  DATA_W  write-back value.
REQ-012 ra_addr, rb_addr  in  3  read-port addresses.
REQ-013 ra_data, rb_data  out  DATA_W  read-port data.
REQ-014 ra_pend, rb_pend  out  1  addressed register awaits write-back.
REQ-015 pend_cnt  out  4  number of registers currently pending (0..7).

Function
REQ-016 R0 SHALL read as 0, ignore writes, never become pending; alloc to R0 SHALL give alloc_ok=1 and change no state.
REQ-017 wb_en=1, wb_addr!=0 SHALL write wb_data into the register at the rising edge and clear its pending bit.
REQ-018 Reads SHALL be combinational, zero latency.
REQ-019 Bypass: if wb_en=1 and wb_addr==ra_addr!=0, ra_data SHALL equal wb_data and ra_pend SHALL be 0 in the same cycle; identically for port b.
REQ-020 alloc_ok SHALL be combinational: 1 if alloc_addr==0, or its pending bit is 0, or a write-back to that address occurs in the same cycle; else 0.
REQ-021 alloc_en=1 with alloc_ok=1 and alloc_addr!=0 SHALL set that pending bit at the edge; alloc_en=1 with alloc_ok=0 SHALL change nothing.
REQ-022 Simultaneous wb and accepted alloc to the same register: data SHALL be written and the pending bit SHALL remain 1 (new reservation wins).
REQ-023 Write-back to a non-pending register SHALL write data; pending stays 0.
REQ-024 pend_cnt SHALL update in the same edge as the pending bits: +1 on set, -1 on clear, net 0 when both occur on different registers or per REQ-022.
REQ-025 pend_cnt SHALL never exceed 7 or underflow; no wrap-around.

Reset
REQ-026 rst_n=0 at a rising edge SHALL clear all registers, all pending bits and pend_cnt, overriding wb_en and alloc_en in that cycle.
REQ-027 After reset: ra_data=rb_data=0, ra_pend=rb_pend=0, pend_cnt=0, alloc_ok=1.
REQ-028 Reset mid-operation SHALL discard all reservations; no in-flight write-back is retained.

Structure
REQ-029 Package reg_file_pkg SHALL hold DATA_W default, NREGS, ADDR_W and the register-array type.
REQ-030 Pending bits, alloc_ok and pend_cnt SHALL live in sub-module reg_scoreboard; reg_file_sb holds the data array, bypass and port muxing.

Verification
REQ-031 Reset, then wb R3=0x00A5; next cycle ra_addr=3 -> ra_data=0x00A5, ra_pend=0.
REQ-032 wb R0=0xFFFF, alloc R0 -> rb_addr=0 reads 0, alloc_ok=1, pend_cnt=0.
REQ-033 alloc R5; next cycle alloc R5 again -> alloc_ok=0, pend_cnt=1; ra_addr=5 -> ra_pend=1.
REQ-034 R5 pending; same cycle wb R5=0x1234 and alloc R5 -> alloc_ok=1, ra_data=0x1234 in that cycle via bypass; after the edge ra_pend=1, pend_cnt=1.
REQ-035 Allocate R1..R7 on consecutive cycles -> pend_cnt=7; wb R2 and alloc R0 together -> pend_cnt=6.
REQ-036 R4 pending and holding 0x0042; assert rst_n=0 with wb R4=0x0099 -> after the edge R4 reads 0, pend_cnt=0, alloc_ok=1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
package reg_file_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int NREGS      = 8;
  localparam int ADDR_W     = 3;
  localparam int CNT_W      = 4;

  typedef logic [ADDR_W-1:0]     reg_addr_t;
  typedef logic [NREGS-1:0]      pend_vec_t;
  typedef logic [DATA_W_DEF-1:0] reg_word_t;
  typedef reg_word_t             reg_array_t [NREGS];

  // Population count of a pending vector.
  function automatic logic [CNT_W-1:0] pend_count(input pend_vec_t v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NREGS; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-bit scoreboard: tracks reserved destinations and grants allocations.
module reg_scoreboard
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_ok,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [NREGS-1:0]  pend,
  output logic [CNT_W-1:0]  pend_cnt
);
  logic      wb_hit;
  logic      alloc_set;
  pend_vec_t clr_mask;
  pend_vec_t set_mask;
  pend_vec_t pend_nxt;

  assign wb_hit = wb_en && (wb_addr != '0);

  // A same-cycle write-back frees the slot, so the reservation can be granted.
  assign alloc_ok = (alloc_addr == '0) || !pend[alloc_addr] ||
                    (wb_hit && (wb_addr == alloc_addr));

  assign alloc_set = alloc_en && alloc_ok && (alloc_addr != '0);

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb_hit)    clr_mask[wb_addr]    = 1'b1;
    if (alloc_set) set_mask[alloc_addr] = 1'b1;
    // Set applied after clear: a new reservation wins over the write-back.
    pend_nxt = (pend & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= pend_count(pend_nxt);
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// 8-entry register file with write-back bypass and a pending-bit scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_ok,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              ra_pend,
  output logic              rb_pend,
  output logic [CNT_W-1:0]  pend_cnt
);
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic              wb_hit;
  logic              ra_byp;
  logic              rb_byp;

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_ok   (alloc_ok),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .pend       (pend),
    .pend_cnt   (pend_cnt)
  );

  assign wb_hit = wb_en && (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // R0 never matches the bypass since wb_hit excludes it.
  assign ra_byp = wb_hit && (wb_addr == ra_addr);
  assign rb_byp = wb_hit && (wb_addr == rb_addr);

  assign ra_data = ra_byp ? wb_data : ((ra_addr == '0) ? '0 : regs[ra_addr]);
  assign rb_data = rb_byp ? wb_data : ((rb_addr == '0) ? '0 : regs[rb_addr]);
  assign ra_pend = pend[ra_addr] && !ra_byp;
  assign rb_pend = pend[rb_addr] && !rb_byp;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with hand-computed expectations.
module tb_reg_file_sb;
  logic        clk;
  logic        rst_n;
  logic        alloc_en;
  logic [2:0]  alloc_addr;
  logic        alloc_ok;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic [15:0] ra_data;
  logic [15:0] rb_data;
  logic        ra_pend;
  logic        rb_pend;
  logic [3:0]  pend_cnt;

  int n_cmp;
  int n_err;

  reg_file_sb #(.DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_ok   (alloc_ok),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .ra_pend    (ra_pend),
    .rb_pend    (rb_pend),
    .pend_cnt   (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_en = 1'b0; alloc_addr = 3'd0;
    wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0000;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    ra_addr = 3'd0;
    rb_addr = 3'd0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    ra_addr = 3'd3; rb_addr = 3'd6; alloc_addr = 3'd5;
    settle();
    chk("rst_ra_data", ra_data, 0);
    chk("rst_rb_data", rb_data, 0);
    chk("rst_ra_pend", ra_pend, 0);
    chk("rst_rb_pend", rb_pend, 0);
    chk("rst_pend_cnt", pend_cnt, 0);
    chk("rst_alloc_ok", alloc_ok, 1);

    // Write R3 then read it back
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h00A5;
    tick();
    idle(); ra_addr = 3'd3;
    settle();
    chk("r3_data", ra_data, 16'h00A5);
    chk("r3_pend", ra_pend, 0);

    // R0 is hardwired and never reserved
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
    alloc_en = 1'b1; alloc_addr = 3'd0; rb_addr = 3'd0;
    settle();
    chk("r0_rb_data", rb_data, 0);
    chk("r0_alloc_ok", alloc_ok, 1);
    chk("r0_pend_cnt", pend_cnt, 0);
    tick();
    idle();
    settle();
    chk("r0_after_data", rb_data, 0);
    chk("r0_after_cnt", pend_cnt, 0);
    chk("r0_after_pend", rb_pend, 0);

    // Double allocation of R5 stalls
    alloc_en = 1'b1; alloc_addr = 3'd5;
    tick();
    ra_addr = 3'd5;
    settle();
    chk("r5_realloc_ok", alloc_ok, 0);
    chk("r5_cnt", pend_cnt, 1);
    chk("r5_pend", ra_pend, 1);
    tick();
    idle();
    settle();
    chk("r5_stall_cnt", pend_cnt, 1);

    // Write-back and re-allocation of R5 in the same cycle
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234;
    alloc_en = 1'b1; alloc_addr = 3'd5;
    settle();
    chk("byp_alloc_ok", alloc_ok, 1);
    chk("byp_ra_data", ra_data, 16'h1234);
    chk("byp_ra_pend", ra_pend, 0);
    tick();
    idle();
    settle();
    chk("byp_after_pend", ra_pend, 1);
    chk("byp_after_cnt", pend_cnt, 1);
    chk("byp_after_data", ra_data, 16'h1234);

    // Release R5, then write a non-pending R6
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h5555;
    tick();
    wb_addr = 3'd6; wb_data = 16'h0BEE;
    tick();
    idle(); rb_addr = 3'd6;
    settle();
    chk("free_cnt", pend_cnt, 0);
    chk("r6_data", rb_data, 16'h0BEE);
    chk("r6_pend", rb_pend, 0);
    chk("r5_clear_pend", ra_pend, 0);

    // Fill the scoreboard
    for (int i = 1; i < 8; i++) begin
      alloc_en = 1'b1; alloc_addr = 3'(i);
      tick();
    end
    idle(); alloc_addr = 3'd3;
    settle();
    chk("full_cnt", pend_cnt, 7);
    chk("full_alloc_ok", alloc_ok, 0);

    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h2222;
    alloc_en = 1'b1; alloc_addr = 3'd0;
    tick();
    idle();
    settle();
    chk("wb2_cnt", pend_cnt, 6);

    // Clear R3 and set R2 together: net zero
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h3333;
    alloc_en = 1'b1; alloc_addr = 3'd2;
    tick();
    idle(); ra_addr = 3'd3; rb_addr = 3'd2;
    settle();
    chk("net0_cnt", pend_cnt, 6);
    chk("net0_r3_pend", ra_pend, 0);
    chk("net0_r2_pend", rb_pend, 1);

    // R4 stays pending while taking 0x0042
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h0042;
    alloc_en = 1'b1; alloc_addr = 3'd4;
    tick();
    idle(); ra_addr = 3'd4;
    settle();
    chk("r4_data", ra_data, 16'h0042);
    chk("r4_pend", ra_pend, 1);

    // Reset overrides a concurrent write-back and allocation
    rst_n = 1'b0;
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h0099;
    alloc_en = 1'b1; alloc_addr = 3'd3;
    tick();
    rst_n = 1'b1;
    idle(); ra_addr = 3'd4; rb_addr = 3'd3; alloc_addr = 3'd4;
    settle();
    chk("rst2_r4_data", ra_data, 0);
    chk("rst2_r4_pend", ra_pend, 0);
    chk("rst2_r3_data", rb_data, 0);
    chk("rst2_cnt", pend_cnt, 0);
    chk("rst2_alloc_ok", alloc_ok, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
